// File: rtl/dragonfang_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dragonfang_pkg: shared execution packet type and FU identifiers            |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package dragonfang_pkg;

    localparam int FU_ID_WIDTH = 3;

    typedef enum logic [FU_ID_WIDTH-1:0] {
        FU_ALU0 = 3'd0,
        FU_ALU1 = 3'd1,
        FU_MUL  = 3'd2,
        FU_LSU  = 3'd3
    } fu_id_e;

    typedef struct packed {
        logic [FU_ID_WIDTH-1:0] functional_unit_id;
        logic [4:0]             opcode;
        logic [31:0]            operand;
    } execution_packet_t;

    function automatic logic fu_id_legal(input logic [FU_ID_WIDTH-1:0] id,
                                         input int unsigned          unit_count);
        return {{(32-FU_ID_WIDTH){1'b0}}, id} < unit_count;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dispatch_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dispatch_fifo: in-order packet queue with separate occupancy count         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module dispatch_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  T                       push_data_i,
    output T                       head_data_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    T                   mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               w_push;
    logic               w_pop;

    assign full_o      = (count_q == CNT_W'(DEPTH));
    assign empty_o     = (count_q == '0);
    assign count_o     = count_q;
    assign head_data_o = mem_q[rd_ptr_q];

    // Guarded so a misbehaving caller can never corrupt the count.
    assign w_push = push_i & ~full_o;
    assign w_pop  = pop_i & ~empty_o;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (w_push && !w_pop) begin
                count_q <= count_q + 1'b1;
            end else if (w_pop && !w_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (w_push && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/functional_unit_dispatch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | functional_unit_dispatch_queue: queued, handshaked per-FU packet dispatch  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module functional_unit_dispatch_queue
    import dragonfang_pkg::*;
#(
    parameter int FUNCTIONAL_UNIT_COUNT = 4,
    parameter int QUEUE_DEPTH           = 4,
    parameter int STALL_COUNTER_WIDTH   = 16
) (
    input  logic                                          clock_i,
    input  logic                                          reset_i,
    input  logic                                          flush_i,
    input  logic                                          packet_valid_i,
    output logic                                          packet_ready_o,
    input  execution_packet_t                             execution_packet_i,
    output logic [FUNCTIONAL_UNIT_COUNT-1:0]              functional_unit_valid_o,
    input  logic [FUNCTIONAL_UNIT_COUNT-1:0]              functional_unit_ready_i,
    output execution_packet_t [FUNCTIONAL_UNIT_COUNT-1:0] functional_unit_input_bus_o,
    output logic [$clog2(QUEUE_DEPTH):0]                  queue_count_o,
    output logic                                          illegal_id_o,
    output logic [STALL_COUNTER_WIDTH-1:0]                stall_count_o
);

    logic                                   w_push;
    logic                                   w_pop;
    logic                                   w_full;
    logic                                   w_empty;
    execution_packet_t                      w_head;
    logic                                   w_head_legal;
    logic                                   w_target_free;
    logic                                   w_dispatch;
    logic                                   w_illegal;
    logic                                   w_stall;
    logic [FUNCTIONAL_UNIT_COUNT-1:0]       w_slot_free;

    logic [FUNCTIONAL_UNIT_COUNT-1:0]              slot_valid_q, slot_valid_d;
    execution_packet_t [FUNCTIONAL_UNIT_COUNT-1:0] slot_data_q,  slot_data_d;
    logic                                          illegal_q,    illegal_d;
    logic [STALL_COUNTER_WIDTH-1:0]                stall_q,      stall_d;

    assign packet_ready_o = ~w_full;
    assign w_push         = packet_valid_i & packet_ready_o;
    assign w_pop          = w_dispatch | w_illegal;

    dispatch_fifo #(
        .DEPTH (QUEUE_DEPTH),
        .T     (execution_packet_t)
    ) u_fifo (
        .clock_i     (clock_i),
        .reset_i     (reset_i),
        .flush_i     (flush_i),
        .push_i      (w_push),
        .pop_i       (w_pop),
        .push_data_i (execution_packet_i),
        .head_data_o (w_head),
        .count_o     (queue_count_o),
        .full_o      (w_full),
        .empty_o     (w_empty)
    );

    assign w_slot_free  = ~slot_valid_q | functional_unit_ready_i;
    assign w_head_legal = fu_id_legal(w_head.functional_unit_id, FUNCTIONAL_UNIT_COUNT);

    always_comb begin
        w_target_free = 1'b0;
        for (int k = 0; k < FUNCTIONAL_UNIT_COUNT; k++) begin
            if (w_head.functional_unit_id == FU_ID_WIDTH'(k)) begin
                w_target_free = w_slot_free[k];
            end
        end
    end

    assign w_dispatch = ~w_empty &  w_head_legal &  w_target_free;
    assign w_illegal  = ~w_empty & ~w_head_legal;
    assign w_stall    = ~w_empty &  w_head_legal & ~w_target_free;

    // A freshly loaded slot wins over its own drain in the same cycle.
    always_comb begin
        slot_valid_d = slot_valid_q;
        slot_data_d  = slot_data_q;
        for (int k = 0; k < FUNCTIONAL_UNIT_COUNT; k++) begin
            if (flush_i) begin
                slot_valid_d[k] = 1'b0;
                slot_data_d[k]  = '0;
            end else if (w_dispatch && (w_head.functional_unit_id == FU_ID_WIDTH'(k))) begin
                slot_valid_d[k] = 1'b1;
                slot_data_d[k]  = w_head;
            end else if (slot_valid_q[k] && functional_unit_ready_i[k]) begin
                slot_valid_d[k] = 1'b0;
                slot_data_d[k]  = '0;
            end
        end
    end

    always_comb begin
        illegal_d = w_illegal & ~flush_i;
        stall_d   = stall_q;
        if (w_stall && !flush_i && (stall_q != {STALL_COUNTER_WIDTH{1'b1}})) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            slot_valid_q <= '0;
            slot_data_q  <= '0;
            illegal_q    <= 1'b0;
            stall_q      <= '0;
        end else begin
            slot_valid_q <= slot_valid_d;
            slot_data_q  <= slot_data_d;
            illegal_q    <= illegal_d;
            stall_q      <= stall_d;
        end
    end

    assign functional_unit_valid_o     = slot_valid_q;
    assign functional_unit_input_bus_o = slot_data_q;
    assign illegal_id_o                = illegal_q;
    assign stall_count_o               = stall_q;

endmodule
`default_nettype wire

// File: tb/tb_functional_unit_dispatch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_functional_unit_dispatch_queue: directed bench with queue-based model   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_functional_unit_dispatch_queue;
    import dragonfang_pkg::*;

    localparam int FU = 4;
    localparam int QD = 4;
    localparam int SW = 16;

    logic                       clock    = 1'b0;
    logic                       reset    = 1'b1;
    logic                       flush    = 1'b0;
    logic                       pv       = 1'b0;
    execution_packet_t          pkt_in   = '0;
    logic [FU-1:0]              fu_ready = '1;
    logic                       packet_ready;
    logic [FU-1:0]              fu_valid;
    execution_packet_t [FU-1:0] fu_bus;
    logic [$clog2(QD):0]        qcount;
    logic                       illegal;
    logic [SW-1:0]              stall;

    int n_checks = 0;
    int n_err    = 0;

    functional_unit_dispatch_queue #(
        .FUNCTIONAL_UNIT_COUNT (FU),
        .QUEUE_DEPTH           (QD),
        .STALL_COUNTER_WIDTH   (SW)
    ) dut (
        .clock_i                     (clock),
        .reset_i                     (reset),
        .flush_i                     (flush),
        .packet_valid_i              (pv),
        .packet_ready_o              (packet_ready),
        .execution_packet_i          (pkt_in),
        .functional_unit_valid_o     (fu_valid),
        .functional_unit_ready_i     (fu_ready),
        .functional_unit_input_bus_o (fu_bus),
        .queue_count_o               (qcount),
        .illegal_id_o                (illegal),
        .stall_count_o               (stall)
    );

    always #5 clock = ~clock;

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic execution_packet_t mk(input int id, input int tag);
        execution_packet_t p;
        p.functional_unit_id = 3'(id);
        p.opcode             = 5'(tag);
        p.operand            = 32'hA000_0000 + 32'(tag);
        return p;
    endfunction

    // Reference model: a plain queue plus per-FU slot mirrors.
    execution_packet_t mq[$];
    logic [FU-1:0]     mvalid;
    execution_packet_t mdata [FU];
    logic              millegal;
    int                mstall;

    always @(posedge clock or posedge reset) begin : p_model
        bit            acc, disp, ill, stl;
        int            hid;
        logic [FU-1:0] freev;
        if (reset) begin
            mq.delete();
            mvalid   = '0;
            foreach (mdata[k]) mdata[k] = '0;
            millegal = 1'b0;
            mstall   = 0;
        end else begin
            acc = pv && (mq.size() < QD);
            if (flush) begin
                mq.delete();
                mvalid   = '0;
                foreach (mdata[k]) mdata[k] = '0;
                millegal = 1'b0;
            end else begin
                freev = ~mvalid | fu_ready;
                disp = 0; ill = 0; stl = 0; hid = 0;
                if (mq.size() > 0) begin
                    hid = int'(mq[0].functional_unit_id);
                    if (hid >= FU)        ill  = 1;
                    else if (freev[hid])  disp = 1;
                    else                  stl  = 1;
                end
                for (int k = 0; k < FU; k++) begin
                    if (disp && k == hid) begin
                        mvalid[k] = 1'b1;
                        mdata[k]  = mq[0];
                    end else if (mvalid[k] && fu_ready[k]) begin
                        mvalid[k] = 1'b0;
                        mdata[k]  = '0;
                    end
                end
                if (disp || ill) void'(mq.pop_front());
                if (acc) mq.push_back(pkt_in);
                millegal = ill;
                if (stl && mstall < 65535) mstall++;
            end
        end
    end

    always @(negedge clock) begin : p_compare
        if (!reset) begin
            check("m_ready", packet_ready, (mq.size() < QD));
            check("m_count", qcount, mq.size());
            check("m_valid", fu_valid, mvalid);
            for (int k = 0; k < FU; k++) check($sformatf("m_bus%0d", k), fu_bus[k], mdata[k]);
            check("m_illegal", illegal, millegal);
            check("m_stall", stall, mstall);
        end
    end

    bit counting = 0;
    int n_seen   = 0;
    int max_cnt  = 0;
    always @(negedge clock) begin : p_tput
        if (counting) begin
            n_seen += $countones(fu_valid);
            if (int'(qcount) > max_cnt) max_cnt = int'(qcount);
        end
    end

    initial begin : p_watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input execution_packet_t p);
        pv     = 1'b1;
        pkt_in = p;
        tick();
        pv     = 1'b0;
    endtask

    initial begin : p_main
        execution_packet_t p3 [5];
        int s0, pulses;

        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("rst_ready", packet_ready, 1);
        check("rst_count", qcount, 0);
        check("rst_valid", fu_valid, 0);
        check("rst_bus", fu_bus, 0);
        check("rst_illegal", illegal, 0);
        check("rst_stall", stall, 0);

        // Test 1: asynchronous reset while 3 queued and 2 slots held
        fu_ready = 4'b1100;
        push(mk(0, 1)); push(mk(1, 2)); push(mk(0, 3)); push(mk(1, 4)); push(mk(0, 5));
        @(negedge clock);
        check("t1_count", qcount, 3);
        check("t1_valid", fu_valid, 4'b0011);
        check("t1_stall", stall, 2);
        #2 reset = 1'b1;
        #1;
        check("t1_async_count", qcount, 0);
        check("t1_async_valid", fu_valid, 0);
        check("t1_async_bus", fu_bus, 0);
        check("t1_async_stall", stall, 0);
        check("t1_async_illegal", illegal, 0);
        fu_ready = '1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("t1_ready_after", packet_ready, 1);

        // Test 2: single packet latency to FU2
        push(mk(2, 6));
        @(negedge clock);
        check("t2_count", qcount, 1);
        check("t2_valid_early", fu_valid, 0);
        @(negedge clock);
        check("t2_valid", fu_valid, 4'b0100);
        check("t2_bus2", fu_bus[2], mk(2, 6));
        check("t2_bus0", fu_bus[0], 0);
        check("t2_bus1", fu_bus[1], 0);
        check("t2_bus3", fu_bus[3], 0);
        @(negedge clock);
        check("t2_drained", fu_valid, 0);

        // Test 3: back-pressure on FU1, queue fills, stall counting, ordered drain
        fu_ready = 4'b1101;
        for (int i = 0; i < 5; i++) begin
            p3[i] = mk(1, 10 + i);
            push(p3[i]);
        end
        @(negedge clock);
        check("t3_ready", packet_ready, 0);
        check("t3_count", qcount, 4);
        check("t3_valid", fu_valid, 4'b0010);
        check("t3_bus1", fu_bus[1], p3[0]);
        check("t3_stall", stall, 3);
        @(negedge clock);
        check("t3_stall_inc", stall, 4);
        fu_ready = '1;
        for (int i = 1; i < 5; i++) begin
            @(negedge clock);
            check($sformatf("t3_order%0d", i), fu_bus[1], p3[i]);
            check($sformatf("t3_v%0d", i), fu_valid[1], 1);
        end
        @(negedge clock);
        check("t3_empty_valid", fu_valid, 0);
        check("t3_stall_hold", stall, 4);

        // Test 4: illegal id dropped, pulse once, next packet dispatched
        push(mk(0, 20)); push(mk(7, 21)); push(mk(3, 22));
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (illegal) pulses++;
            if (i == 1) begin
                check("t4_valid3", fu_valid, 4'b1000);
                check("t4_bus3", fu_bus[3], mk(3, 22));
            end
        end
        check("t4_pulses", pulses, 1);

        // Test 5: flush beats a same-cycle push and pending dispatch
        s0 = int'(stall);
        push(mk(2, 30));
        flush  = 1'b1;
        pv     = 1'b1;
        pkt_in = mk(1, 31);
        tick();
        flush = 1'b0;
        pv    = 1'b0;
        @(negedge clock);
        check("t5_count", qcount, 0);
        check("t5_valid", fu_valid, 0);
        check("t5_stall", stall, s0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check($sformatf("t5_lost%0d", i), fu_valid, 0);
        end

        // Test 6: continuous streaming with pointer wrap
        counting = 1;
        for (int i = 0; i < 20; i++) begin
            pv     = 1'b1;
            pkt_in = mk(i % 4, 40 + i);
            tick();
        end
        pv = 1'b0;
        repeat (4) @(negedge clock);
        counting = 0;
        check("t6_seen", n_seen, 20);
        check("t6_maxcount", max_cnt, 1);

        repeat (2) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
